// File: rtl/qspi_flash_sequencer_if.sv
// Register-window bus between the flash sequencer and the QSPI master.
// The sequencer is the only master of this port.
interface qspi_flash_sequencer_if;
  logic        bus_write;
  logic [3:0]  bus_be;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_write,
    output bus_be,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_write,
    input  bus_be,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/qspi_flash_sequencer.sv
// Turns READ / PROGRAM / ERASE requests into QSPI master register sequences.
// Optional QSPI_SEQ_POLL_TIMEOUT_EN bounds RDSR1 polling to POLL_LIMIT frames.
module qspi_flash_sequencer #(
  parameter logic [5:0]  PRESCALER  = 6'd2,
  parameter logic [7:0]  OP_READ    = 8'h6B,
  parameter logic [7:0]  OP_PP      = 8'h32,
  parameter logic [7:0]  OP_SE      = 8'hD8,
  parameter logic [15:0] POLL_LIMIT = 16'd50000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [23:0] req_addr_i,
  input  logic [4:0]  req_len_i,
  output logic        dat_rd_o,
  input  logic [31:0] dat_i,
  output logic        dat_we_o,
  output logic [2:0]  dat_idx_o,
  output logic [31:0] dat_o,
  output logic        done_o,
  output logic        err_o,
  qspi_flash_sequencer_if.master bus
);

  localparam logic [5:0] AddrCcr = 6'd0;
  localparam logic [5:0] AddrAdr = 6'd4;
  localparam logic [5:0] AddrDr0 = 6'd8;
  localparam logic [5:0] AddrSta = 6'd40;

  localparam int unsigned BusyCycles = 8 * (32'(PRESCALER) + 1);
  localparam logic [9:0]  BusyLast   = 10'(BusyCycles - 1);

  typedef enum logic [3:0] {
    StIdle, StWren, StAdr, StLoadRd, StLoadWr, StStart, StWaitBusy, StWaitIdle,
    StUnloadRd, StUnloadWr, StPollStart, StPollRd, StPollChk, StDone
  } state_e;

  typedef enum logic [1:0] {OpRead = 2'd0, OpProg = 2'd1, OpErase = 2'd2, OpRsvd = 2'd3} op_e;

  // Which frame the shared completion wait belongs to.
  typedef enum logic [1:0] {CtxWren, CtxOp, CtxPoll} ctx_e;

  state_e      state_q, state_d;
  ctx_e        ctx_q, ctx_d;
  op_e         op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic [4:0]  len_q, len_d;
  logic [2:0]  word_q, word_d;
  logic [9:0]  busy_cnt_q, busy_cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
  logic [15:0] poll_cnt_q, poll_cnt_d;
`endif

  logic [5:0]  dr_addr;
  assign dr_addr = AddrDr0 + {1'b0, word_q, 2'b00};

  function automatic logic [31:0] ccr_word(logic [4:0] size, logic [4:0] dummy, logic wr,
                                           logic [1:0] mode, logic [7:0] opc);
    return {1'b1, PRESCALER, 4'b0000, size, dummy, wr, mode, opc};
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ctx_q      <= CtxWren;
      op_q       <= OpRead;
      addr_q     <= '0;
      len_q      <= '0;
      word_q     <= '0;
      busy_cnt_q <= '0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
      poll_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctx_q      <= ctx_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      word_q     <= word_d;
      busy_cnt_q <= busy_cnt_d;
      err_flag_q <= err_flag_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
      poll_cnt_q <= poll_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ctx_d      = ctx_q;
    op_d       = op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    word_d     = word_q;
    busy_cnt_d = '0;
    err_flag_d = err_flag_q;
    done_d     = (state_q == StDone);
    err_d      = (state_q == StDone) & err_flag_q;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d       = op_e'(req_op_i);
          addr_d     = req_addr_i;
          len_d      = req_len_i;
          word_d     = '0;
          err_flag_d = 1'b0;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
          case (op_e'(req_op_i))
            OpRead:          state_d = StAdr;
            OpProg, OpErase: state_d = StWren;
            default: begin
              state_d    = StDone;
              err_flag_d = 1'b1;
            end
          endcase
        end
      end
      StWren: begin
        ctx_d   = CtxWren;
        state_d = StWaitBusy;
      end
      StAdr:    state_d = (op_q == OpRead) ? StStart : StLoadRd;
      StLoadRd: state_d = StLoadWr;
      StLoadWr: begin
        word_d  = word_q + 3'd1;
        state_d = (op_q == OpErase || word_q == len_q[4:2]) ? StStart : StLoadRd;
      end
      StStart: begin
        ctx_d   = CtxOp;
        word_d  = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        // The first cycle's read data still belongs to the CCR write address.
        busy_cnt_d = busy_cnt_q + 10'd1;
        if ((busy_cnt_q != '0 && bus.bus_rdata != 32'd1) || busy_cnt_q == BusyLast) begin
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (bus.bus_rdata == 32'd1) begin
          case (ctx_q)
            CtxWren: state_d = (op_q == OpProg) ? StAdr : StLoadWr;
            CtxOp:   state_d = (op_q == OpRead) ? StUnloadRd : StPollStart;
            default: state_d = StPollRd;
          endcase
        end
      end
      StUnloadRd: state_d = StUnloadWr;
      StUnloadWr: begin
        word_d  = word_q + 3'd1;
        state_d = (word_q == len_q[4:2]) ? StDone : StUnloadRd;
      end
      StPollStart: begin
        ctx_d   = CtxPoll;
        state_d = StWaitBusy;
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q + 16'd1;
`endif
      end
      StPollRd: state_d = StPollChk;
      StPollChk: begin
        if (bus.bus_rdata[0]) begin
`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
          if (poll_cnt_q >= POLL_LIMIT) begin
            state_d    = StDone;
            err_flag_d = 1'b1;
          end else begin
            state_d = StPollStart;
          end
`else
          state_d = StPollStart;
`endif
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        word_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_o   = 1'b0;
    dat_rd_o      = 1'b0;
    dat_we_o      = 1'b0;
    dat_idx_o     = word_q;
    dat_o         = '0;
    bus.bus_write = 1'b0;
    bus.bus_be    = 4'hF;
    bus.bus_addr  = AddrSta;
    bus.bus_wdata = '0;
    case (state_q)
      StIdle: req_ready_o = 1'b1;
      StWren: begin
        bus.bus_write = 1'b1;
        bus.bus_addr  = AddrCcr;
        bus.bus_wdata = ccr_word(5'd0, 5'd0, 1'b0, 2'd0, 8'h06);
      end
      StAdr: begin
        bus.bus_write = 1'b1;
        bus.bus_addr  = AddrAdr;
        bus.bus_wdata = {addr_q, 8'h00};
      end
      StLoadRd: dat_rd_o = 1'b1;
      StLoadWr: begin
        bus.bus_write = 1'b1;
        bus.bus_addr  = dr_addr;
        // Erase sends the address MSB-first as three data bytes.
        bus.bus_wdata = (op_q == OpErase) ? {8'h00, addr_q[7:0], addr_q[15:8], addr_q[23:16]}
                                          : dat_i;
      end
      StStart: begin
        bus.bus_write = 1'b1;
        bus.bus_addr  = AddrCcr;
        case (op_q)
          OpRead:  bus.bus_wdata = ccr_word(len_q, 5'd4, 1'b0, 2'd3, OP_READ);
          OpProg:  bus.bus_wdata = ccr_word(len_q, 5'd3, 1'b1, 2'd3, OP_PP);
          default: bus.bus_wdata = ccr_word(5'd2, 5'd0, 1'b1, 2'd1, OP_SE);
        endcase
      end
      StUnloadRd: bus.bus_addr = dr_addr;
      StUnloadWr: begin
        dat_we_o = 1'b1;
        dat_o    = bus.bus_rdata;
      end
      StPollStart: begin
        bus.bus_write = 1'b1;
        bus.bus_addr  = AddrCcr;
        bus.bus_wdata = ccr_word(5'd0, 5'd0, 1'b0, 2'd1, 8'h05);
      end
      StPollRd: bus.bus_addr = AddrDr0;
      default: ;
    endcase
  end

  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Directed bench for qspi_flash_sequencer with a behavioural QSPI master register model.
module tb_qspi_flash_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [23:0] req_addr = '0;
  logic [4:0]  req_len = '0;
  logic        dat_rd;
  logic [31:0] dat_in = '0;
  logic        dat_we;
  logic [2:0]  dat_idx;
  logic [31:0] dat_out;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  qspi_flash_sequencer_if bus_if ();

  qspi_flash_sequencer #(.POLL_LIMIT(16'd4)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .dat_rd_o    (dat_rd),
    .dat_i       (dat_in),
    .dat_we_o    (dat_we),
    .dat_idx_o   (dat_idx),
    .dat_o       (dat_out),
    .done_o      (done),
    .err_o       (err),
    .bus         (bus_if)
  );

  function automatic logic [31:0] dat_pat(int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {16'hC0DE, kb, ~kb};
  endfunction

  function automatic logic [31:0] rd_pat(logic [31:0] adr, int k);
    logic [7:0] kb;
    kb = 8'(k);
    return adr ^ {kb, kb, kb, kb} ^ 32'h5A5A_0000;
  endfunction

  // QSPI master register model
  logic [31:0] m_dr [8];
  logic [31:0] m_adr = '0;
  int          m_busy = 0;
  int          m_busy_len = 3;
  int          m_rdsr_cnt = 0;
  int          rdsr_base = 0;
  int          wip_target = 0;

  always @(posedge clk) begin
    if (bus_if.bus_write) begin
      if (bus_if.bus_addr == 6'd0 && bus_if.bus_wdata[31]) begin
        m_busy <= m_busy_len;
        if (bus_if.bus_wdata[7:0] == 8'h05) begin
          m_dr[0]    <= {31'd0, ((m_rdsr_cnt - rdsr_base) < wip_target)};
          m_rdsr_cnt <= m_rdsr_cnt + 1;
        end else if (bus_if.bus_wdata[7:0] == 8'h6B) begin
          for (int k = 0; k < 8; k++) m_dr[k] <= rd_pat(m_adr, k);
        end
      end else if (bus_if.bus_addr == 6'd4) begin
        m_adr <= bus_if.bus_wdata;
      end else if (bus_if.bus_addr >= 6'd8 && bus_if.bus_addr <= 6'd36) begin
        m_dr[3'((bus_if.bus_addr - 6'd8) >> 2)] <= bus_if.bus_wdata;
      end
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
    end
    if (bus_if.bus_addr == 6'd40)
      bus_if.bus_rdata <= (m_busy == 0) ? 32'd1 : 32'd0;
    else if (bus_if.bus_addr >= 6'd8 && bus_if.bus_addr <= 6'd36)
      bus_if.bus_rdata <= m_dr[3'((bus_if.bus_addr - 6'd8) >> 2)];
    else
      bus_if.bus_rdata <= 32'd0;
    if (dat_rd) dat_in <= dat_pat(int'(dat_idx));
  end

  // Transaction log
  logic [31:0] ccr_q [$];
  logic [31:0] adr_q [$];
  logic [37:0] dr_q  [$];
  logic [34:0] we_q  [$];
  int          wr_cnt = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (bus_if.bus_write) begin
      wr_cnt <= wr_cnt + 1;
      if (bus_if.bus_addr == 6'd0) ccr_q.push_back(bus_if.bus_wdata);
      else if (bus_if.bus_addr == 6'd4) adr_q.push_back(bus_if.bus_wdata);
      else dr_q.push_back({bus_if.bus_addr, bus_if.bus_wdata});
    end
    if (dat_we) we_q.push_back({dat_idx, dat_out});
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [23:0] addr;
    logic [4:0]  len;
    int          wip;
    logic [31:0] ccr;
    int          n_adr;
    int          n_dr;
    logic [31:0] dr0;
    int          n_we;
    int          n_rdsr;
    logic        err;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int cb, ab, db, wb, n_rdsr, n_ccr;
    bit seen;
    logic got_err;
    logic [31:0] op_ccr;
    logic [31:0] exp_data;
    cb = ccr_q.size(); ab = adr_q.size(); db = dr_q.size(); wb = we_q.size();
    rdsr_base = m_rdsr_cnt;
    wip_target = v.wip;
    @(negedge clk);
    req_op = v.op; req_addr = v.addr; req_len = v.len; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("v%0d first write", id), 32'(bus_if.bus_write), 32'd1);
    chk($sformatf("v%0d first addr", id), 32'(bus_if.bus_addr),
        (v.op == 2'd0) ? 32'd4 : 32'd0);
    seen = 1'b0;
    got_err = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        got_err = err;
        break;
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d done seen", id), 32'(seen), 32'd1);
    chk($sformatf("v%0d err", id), 32'(got_err), 32'(v.err));
    op_ccr = '0;
    n_rdsr = 0;
    n_ccr = ccr_q.size() - cb;
    for (int i = cb; i < ccr_q.size(); i++) begin
      if (ccr_q[i][7:0] == v.ccr[7:0]) op_ccr = ccr_q[i];
      if (ccr_q[i][7:0] == 8'h05) n_rdsr++;
    end
    chk($sformatf("v%0d op ccr", id), op_ccr, v.ccr);
    chk($sformatf("v%0d rdsr frames", id), 32'(n_rdsr), 32'(v.n_rdsr));
    chk($sformatf("v%0d ccr count", id), 32'(n_ccr),
        32'(((v.op != 2'd0) ? 1 : 0) + 1 + v.n_rdsr));
    if (v.op != 2'd0 && n_ccr > 0)
      chk($sformatf("v%0d wren word", id), ccr_q[cb], 32'h8400_0006);
    chk($sformatf("v%0d adr count", id), 32'(adr_q.size() - ab), 32'(v.n_adr));
    if (adr_q.size() > ab)
      chk($sformatf("v%0d adr word", id), adr_q[ab], {v.addr, 8'h00});
    chk($sformatf("v%0d dr count", id), 32'(dr_q.size() - db), 32'(v.n_dr));
    for (int k = 0; k < dr_q.size() - db; k++) begin
      exp_data = (v.op == 2'd2) ? v.dr0 : dat_pat(k);
      chk($sformatf("v%0d dr%0d addr", id, k), 32'(dr_q[db + k][37:32]), 32'(8 + 4 * k));
      chk($sformatf("v%0d dr%0d data", id, k), dr_q[db + k][31:0], exp_data);
    end
    chk($sformatf("v%0d we count", id), 32'(we_q.size() - wb), 32'(v.n_we));
    for (int k = 0; k < we_q.size() - wb; k++) begin
      chk($sformatf("v%0d we%0d idx", id, k), 32'(we_q[wb + k][34:32]), 32'(k));
      chk($sformatf("v%0d we%0d data", id, k), we_q[wb + k][31:0],
          rd_pat({v.addr, 8'h00}, k));
    end
  endtask

  vec_t vecs [7];

  initial begin
    int cb, wc, dc;
    bit seen;
    vecs[0] = '{2'd0, 24'h001000, 5'd7,  0, 32'h8407_236B, 1, 0, 32'h0,          2, 0, 1'b0};
    vecs[1] = '{2'd1, 24'h000100, 5'd3,  2, 32'h8403_1F32, 1, 1, 32'hC0DE_00FF, 0, 3, 1'b0};
    vecs[2] = '{2'd2, 24'h030000, 5'd0,  1, 32'h8402_05D8, 0, 1, 32'h0000_0003, 0, 2, 1'b0};
    vecs[3] = '{2'd0, 24'h0ABCDE, 5'd0,  0, 32'h8400_236B, 1, 0, 32'h0,          1, 0, 1'b0};
    vecs[4] = '{2'd1, 24'h123456, 5'd31, 0, 32'h841F_1F32, 1, 8, 32'hC0DE_00FF, 0, 1, 1'b0};
    vecs[5] = '{2'd0, 24'h7FFFFC, 5'd31, 0, 32'h841F_236B, 1, 0, 32'h0,          8, 0, 1'b0};
    vecs[6] = '{2'd2, 24'hFFEEDD, 5'd9,  0, 32'h8402_05D8, 0, 1, 32'h00DD_EEFF, 0, 1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst bus_write", 32'(bus_if.bus_write), 32'd0);
    chk("rst bus_addr", 32'(bus_if.bus_addr), 32'd40);
    chk("rst bus_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst bus_be", 32'(bus_if.bus_be), 32'hF);
    chk("rst dat_idx", 32'(dat_idx), 32'd0);
    chk("rst dat_o", dat_out, 32'd0);
    chk("rst strobes", {28'd0, dat_rd, dat_we, done, err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reserved op: done+err two cycles after the handshake, no bus traffic.
    wc = wr_cnt;
    @(negedge clk);
    req_op = 2'd3; req_addr = 24'h0; req_len = 5'd0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rsv c1 done", 32'(done), 32'd0);
    chk("rsv c1 ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rsv c2 done", 32'(done), 32'd1);
    chk("rsv c2 err", 32'(err), 32'd1);
    @(negedge clk);
    chk("rsv c3 done", 32'(done), 32'd0);
    @(negedge clk);
    chk("rsv no writes", 32'(wr_cnt - wc), 32'd0);

    // Reset while waiting for a long frame to finish.
    m_busy_len = 30;
    cb = ccr_q.size();
    @(negedge clk);
    req_op = 2'd0; req_addr = 24'h000200; req_len = 5'd3; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ccr_q.size() > cb) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rstmid ccr seen", 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    chk("rstmid busy ready", 32'(req_ready), 32'd0);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid ready", 32'(req_ready), 32'd1);
    chk("rstmid bus_write", 32'(bus_if.bus_write), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstmid no done", 32'(done_cnt - dc), 32'd0);
    m_busy_len = 3;
    run_vec(vecs[0], 10);

`ifdef QSPI_SEQ_POLL_TIMEOUT_EN
    begin
      vec_t tv;
      tv = '{2'd1, 24'h000200, 5'd0, 1000, 32'h8400_1F32, 1, 1, 32'hC0DE_00FF, 0, 4, 1'b1};
      run_vec(tv, 20);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
